// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes and controller state encoding shared by the keypad entry blocks
package keypad_pkg;

    localparam logic [3:0] KEY_ENTER = 4'd10;
    localparam logic [3:0] KEY_CLEAR = 4'd11;
    localparam logic [3:0] KEY_BKSP  = 4'd12;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_e;

endpackage

// File: rtl/keypad_entry_ctrl_bcd2bin_seq.sv
// bcd2bin_seq: iterative BCD-to-binary converter, one digit per cycle, most significant digit first
module bcd2bin_seq
    import keypad_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int BIN_W  = 4 * DIGITS,
    localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bcd,
    output logic [BIN_W-1:0] value,
    output logic             done
);

    logic [BIN_W-1:0] acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             run_q, run_d;
    logic [3:0]       digit;

    assign digit = bcd[{idx_q, 2'b00} +: 4];
    assign value = acc_q;
    // done marks the cycle whose edge applies the final (least significant) digit
    assign done  = run_q && (idx_q == '0);

    // next-state: load on start, then multiply-accumulate until the last digit slot
    always_comb begin
        acc_d = acc_q;
        idx_d = idx_q;
        run_d = run_q;
        if (start) begin
            acc_d = '0;
            idx_d = IW'(DIGITS - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
            idx_d = idx_q - 1'b1;
            run_d = (idx_q != '0);
        end
    end

    // converter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            idx_q <= '0;
            run_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: keypad digit entry with editing, timeout, BCD-to-binary conversion and valid/ready output
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter  int DIGITS         = 4,
    parameter  int TIMEOUT_CYCLES = 50_000_000,
    localparam int BIN_W          = 4 * DIGITS,
    localparam int CW             = $clog2(DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       key_code,
    input  logic             key_valid,
    output logic [BIN_W-1:0] entry_bcd,
    output logic [CW-1:0]    digit_count,
    output logic [BIN_W-1:0] value_bin,
    output logic             value_valid,
    input  logic             value_ready,
    output logic             busy,
    output logic             err,
    output logic             timeout
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [BIN_W-1:0] entry_q, entry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             tmo_q, tmo_d;
    logic             conv_start, conv_done;

    bcd2bin_seq #(.DIGITS(DIGITS)) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bcd   (entry_q),
        .value (value_bin),
        .done  (conv_done)
    );

    assign entry_bcd   = entry_q;
    assign digit_count = cnt_q;
    assign value_valid = valid_q;
    assign busy        = busy_q;
    assign err         = err_q;
    assign timeout     = tmo_q;

    // next-state: key editing and inactivity timeout in ENTRY, key rejection while busy, handshake in HOLD
    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        valid_d    = valid_q;
        err_d      = 1'b0;
        tmo_d      = 1'b0;
        conv_start = 1'b0;
        case (state_q)
            ENTRY: begin
                if (key_valid) begin
                    tcnt_d = '0;
                    if (key_code < KEY_ENTER) begin
                        if (cnt_q < CW'(DIGITS)) begin
                            entry_d = {entry_q[BIN_W-5:0], key_code};
                            cnt_d   = cnt_q + 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (cnt_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            conv_start = 1'b1;
                            state_d    = CONVERT;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        entry_d = '0;
                        cnt_d   = '0;
                    end else if (key_code == KEY_BKSP && cnt_q != '0) begin
                        entry_d = entry_q >> 4;
                        cnt_d   = cnt_q - 1'b1;
                    end
                end else if (TIMEOUT_CYCLES != 0 && cnt_q != '0) begin
                    if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        entry_d = '0;
                        cnt_d   = '0;
                        tcnt_d  = '0;
                        tmo_d   = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            CONVERT: begin
                err_d = key_valid;
                if (conv_done) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                err_d = key_valid;
                if (value_ready) begin
                    state_d = ENTRY;
                    valid_d = 1'b0;
                    entry_d = '0;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end
            end
            default: state_d = ENTRY;
        endcase
        busy_d = (state_d != ENTRY);
    end

    // controller state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENTRY;
            entry_q <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencing controller placed after the 4x4 keypad scanner. It consumes single-cycle key events, assembles a right-justified multi-digit decimal entry with clear and backspace editing, and shows the live entry on the display. On ENTER it converts the entry to binary over several cycles and presents it to the consumer, for example the calculator/ALU stage, through a valid/ready handshake. It also clears a stale entry after an inactivity timeout.

## Interface
- DIGITS, 4: maximum digits per entry; BIN_W = 4*DIGITS.
- TIMEOUT_CYCLES, 50_000_000: inactivity limit in clock cycles; 0 disables the timeout.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_code  in  4  scanner key code, 0..15.
- key_valid  in  1  one-cycle pulse qualifying key_code (scanner data_ready).
- entry_bcd  out  4*DIGITS  live entry, BCD, right-justified, newest digit in [3:0].
- digit_count  out  $clog2(DIGITS+1)  number of digits entered.
- value_bin  out  BIN_W  converted value; stable while value_valid=1.
- value_valid  out  1  value_bin offered to the consumer.
- value_ready  in  1  consumer accepts the value when value_valid & value_ready.
- busy  out  1  high in CONVERT and HOLD.
- err  out  1  one-cycle pulse when a key is rejected.
- timeout  out  1  one-cycle pulse when the entry is auto-cleared.

## Operation
- Key map: 0-9 = digit, 10 = ENTER, 11 = CLEAR, 12 = BACKSPACE, 13-15 = no-op (no err pulse).
- States: ENTRY, CONVERT, HOLD.
- ENTRY transitions:
  - Digit with digit_count<DIGITS: entry_bcd <= {entry_bcd[4*DIGITS-5:0], d}; count+1.
  - Digit with digit_count==DIGITS: ignored; err pulse.
  - BACKSPACE: entry_bcd >>= 4; count-1. When count==0: no-op; no err.
  - CLEAR: entry_bcd=0; count=0.
  - ENTER with count==0: err pulse; stay in ENTRY.
  - ENTER with count>0: value_bin<=0, idx<=DIGITS-1, go to CONVERT.
- CONVERT: one BCD digit per cycle, MSD first: value_bin <= value_bin*10 + entry_bcd[4*idx+:4]. Leading zero slots are processed too, so CONVERT always takes exactly DIGITS cycles. After the idx==0 step, go to HOLD.
- HOLD: value_valid=1. On the handshake cycle: value_valid<=0, entry_bcd<=0, count<=0, go to ENTRY.
- Any key_valid while busy: key dropped, err pulse, no state change.
- Timeout counter:
  - Reset to 0 on every accepted key.
  - Counts only in ENTRY with count>0.
  - When it reaches TIMEOUT_CYCLES-1: clear the entry, pulse timeout, reset the counter.
  - A key arriving on that same cycle wins: it is processed and the timeout is cancelled.
- Arithmetic: value_bin*10 computed as (v<<3)+(v<<1) in BIN_W bits. No overflow is possible because 10^DIGITS-1 < 2^BIN_W.

## Timing
- Reset values: entry_bcd=0, digit_count=0, value_bin=0, value_valid=0, busy=0, err=0, timeout=0, state=ENTRY, timeout counter=0.
- All outputs are registered. A key sampled at edge N is reflected in entry_bcd/digit_count after edge N.
- ENTER sampled at edge E0: busy=1 after E0; value_valid=1 after edge E0+DIGITS.
- value_valid, once high, stays high with value_bin stable until the handshake. value_ready is ignored at all other times.
- value_valid falls and entry_bcd clears after the handshake edge. A key on the cycle after that edge is accepted normally.
- err and timeout are exactly one cycle wide.
- Reset mid-CONVERT or mid-HOLD aborts immediately: outputs go to reset values and the value is never offered.

## Structure
- Shared package keypad_pkg holds:
  - Key constants: KEY_ENTER=4'd10, KEY_CLEAR=4'd11, KEY_BKSP=4'd12.
  - The state encoding: ENTRY=2'd0, CONVERT=2'd1, HOLD=2'd2.
- One sub-module, bcd2bin_seq, contains the iterative multiply-accumulate converter with start/done signals. The FSM, edit logic and timeout stay in the top module.

## Test plan
- DIGITS=4. Keys 1,2,3, ENTER -> entry_bcd=16'h0123, count=3. value_valid rises exactly 4 cycles after the ENTER edge with value_bin=123. Entry clears after the handshake.
- Keys 9,9,9,9,5 -> fifth key gives an err pulse. ENTER -> value_bin=9999.
- Keys 4,5, BACKSPACE, 7, ENTER -> value_bin=47. BACKSPACE with count=0 gives no err. CLEAR mid-entry -> entry_bcd=0, count=0.
- Hold value_ready=0 for 20 cycles in HOLD while pulsing key 3 -> value_bin stays at its value. Each key gives err and is dropped. value_ready=1 -> handshake, then ENTRY.
- TIMEOUT_CYCLES=100, key 8 then idle -> timeout pulse and entry cleared after 100 cycles. Repeat with a key landing on the expiry cycle -> no timeout, key applied.
- Assert reset during CONVERT -> all outputs at reset values next cycle. Value never offered.
